// File: rtl/clk_mgmt_pkg.sv
// Shared definitions for the DCM clock-management supervisor: FSM states,
// clock-tree constants and the expected-transition helper.
package clk_mgmt_pkg;

  typedef enum logic [2:0] {
    ST_DCM_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_MEASURE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } sup_state_e;

  localparam int DIV_RATIO   = 10;
  localparam int CLK_IN_HZ   = 50_000_000;
  localparam int SYNC_STAGES = 2;

  // The returned toggle flips once per derived-clock cycle, so one transition
  // arrives every DIV_RATIO board-clock cycles.
  function automatic int expected_count(input int window, input int div_ratio);
    return window / div_ratio;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow, asynchronous level signals; resets to 0.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clk_lock_supervisor.sv
// Sequences the DCM reset, waits for LOCKED, verifies the divided clock by
// counting returned-toggle transitions per window, and retries or faults.
module clk_lock_supervisor
  import clk_mgmt_pkg::*;
#(
  parameter int RST_CYCLES   = 8,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int WINDOW       = 1000,
  parameter int EXPECTED     = expected_count(WINDOW, DIV_RATIO),
  parameter int TOL          = 2,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lock_in,
  input  logic       tog_in,
  output logic       dcm_rst,
  output logic       clk_ok,
  output logic       fault,
  output logic [1:0] retries
);

  localparam int TW = $clog2(LOCK_TIMEOUT > RST_CYCLES ? LOCK_TIMEOUT : RST_CYCLES);
  localparam int WW = $clog2(WINDOW);
  localparam logic [7:0] CNT_LO = 8'(EXPECTED - TOL);
  localparam logic [7:0] CNT_HI = 8'(EXPECTED + TOL);

  logic lock_s, tog_s, tog_d_q;
  logic trans;

  sync_2ff #(.W(1)) u_sync_lock (.clk(clk), .rst(rst), .d(lock_in), .q(lock_s));
  sync_2ff #(.W(1)) u_sync_tog  (.clk(clk), .rst(rst), .d(tog_in),  .q(tog_s));

  sup_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [WW-1:0] win_q, win_d;
  logic [7:0]    cnt_q, cnt_d, cnt_inc;
  logic [1:0]    retries_q, retries_d;
  logic          dcm_rst_q, dcm_rst_d;
  logic          clk_ok_q, clk_ok_d;
  logic          fault_q, fault_d;
  logic          win_last, in_range, fail;

  assign trans    = tog_s ^ tog_d_q;
  // The window verdict includes a transition detected on the last cycle itself.
  assign cnt_inc  = (trans && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
  assign win_last = (win_q == WW'(WINDOW - 1));
  assign in_range = (cnt_inc >= CNT_LO) && (cnt_inc <= CNT_HI);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    fail      = 1'b0;
    case (state_q)
      ST_DCM_RST: begin
        if (timer_q == TW'(RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_MEASURE;
          timer_d = '0;
          win_d   = '0;
          cnt_d   = '0;
        end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
          fail = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_MEASURE, ST_RUN: begin
        // Losing lock outranks a window verdict in the same cycle.
        if (!lock_s) begin
          fail = 1'b1;
        end else if (win_last) begin
          if (in_range) begin
            state_d   = ST_RUN;
            retries_d = 2'd0;
            win_d     = '0;
            cnt_d     = '0;
          end else begin
            fail = 1'b1;
          end
        end else begin
          win_d = win_q + 1'b1;
          cnt_d = cnt_inc;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_DCM_RST;
        timer_d = '0;
      end
    endcase
    if (fail) begin
      timer_d = '0;
      if (retries_q != 2'd3) retries_d = retries_q + 2'd1;
      state_d = (retries_q == 2'(MAX_RETRIES - 1)) ? ST_FAULT : ST_DCM_RST;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    dcm_rst_d = (state_d == ST_DCM_RST) || (state_d == ST_FAULT);
    clk_ok_d  = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DCM_RST;
      timer_q   <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      retries_q <= 2'd0;
      tog_d_q   <= 1'b0;
      dcm_rst_q <= 1'b1;
      clk_ok_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      tog_d_q   <= tog_s;
      dcm_rst_q <= dcm_rst_d;
      clk_ok_q  <= clk_ok_d;
      fault_q   <= fault_d;
    end
  end

  assign dcm_rst = dcm_rst_q;
  assign clk_ok  = clk_ok_q;
  assign fault   = fault_q;
  assign retries = retries_q;

endmodule

// File: tb/tb_clk_lock_supervisor.sv
// Directed bench for clk_lock_supervisor; step offsets are counted in falling
// clock edges from the edge at which rst is released or lock_in is raised.
module tb_clk_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock_in = 1'b0;
  logic       tog_in = 1'b0;
  logic       dcm_rst, clk_ok, fault;
  logic [1:0] retries;

  int n_chk  = 0;
  int n_pass = 0;

  // Toggle generator: tog_left < 0 runs forever, > 0 emits that many edges.
  int tog_period = 10;
  int tog_left   = 0;
  int tog_ph     = 0;

  int bnd_n[4]    = '{98, 102, 97, 103};
  int bnd_pass[4] = '{1, 1, 0, 0};

  always #10 clk = ~clk;

  clk_lock_supervisor #(
    .LOCK_TIMEOUT(200)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .lock_in(lock_in),
    .tog_in (tog_in),
    .dcm_rst(dcm_rst),
    .clk_ok (clk_ok),
    .fault  (fault),
    .retries(retries)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (tog_left != 0) begin
        if (tog_ph >= tog_period - 1) begin
          tog_in = ~tog_in;
          tog_ph = 0;
          if (tog_left > 0) tog_left--;
        end else begin
          tog_ph++;
        end
      end
    end
  end

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(2);
    chk("reset_dcm_rst", dcm_rst, 1);
    chk("reset_clk_ok", clk_ok, 0);
    chk("reset_fault", fault, 0);
    chk("reset_retries", retries, 0);

    // Nominal bring-up with a correct 1-in-10 toggle
    tog_period = 10; tog_ph = 0; tog_left = -1;
    rst = 1'b0;
    tick(7);   chk("nom_dcm_rst_held", dcm_rst, 1);
    tick(1);   chk("nom_dcm_rst_fall", dcm_rst, 0);
    tick(20);  lock_in = 1'b1;
    tick(1002); chk("nom_clk_ok_early", clk_ok, 0);
    tick(1);   chk("nom_clk_ok", clk_ok, 1);
    chk("nom_retries", retries, 0);
    chk("nom_dcm_rst_low", dcm_rst, 0);
    tick(1500); chk("nom_run_windows", clk_ok, 1);

    // One-cycle lock loss in RUN, then relock
    lock_in = 1'b0;
    tick(1);   lock_in = 1'b1;
    tick(1);   chk("loss_clk_ok_hold", clk_ok, 1);
    tick(1);   chk("loss_clk_ok_drop", clk_ok, 0);
    chk("loss_dcm_rst", dcm_rst, 1);
    chk("loss_retries", retries, 1);
    tick(1020); chk("relock_clk_ok", clk_ok, 1);
    chk("relock_retries", retries, 0);

    // Asynchronous reset while in RUN
    tick(3);
    #3 rst = 1'b1;
    #1 chk("arst_run_clk_ok", clk_ok, 0);
    chk("arst_run_dcm_rst", dcm_rst, 1);

    // Wrong frequency: 1-in-9 toggle gives 111..112 transitions
    tick(2);
    tog_period = 9; tog_ph = 0; tog_left = -1;
    lock_in = 1'b1;
    rst = 1'b0;
    tick(1008); chk("wf_dcm_rst_pre", dcm_rst, 0);
    chk("wf_retries_pre", retries, 0);
    tick(1);   chk("wf_dcm_rst", dcm_rst, 1);
    chk("wf_retries", retries, 1);
    chk("wf_clk_ok", clk_ok, 0);

    // Asynchronous reset mid-MEASURE of the retry
    tick(500);
    #3 rst = 1'b1;
    #1 chk("arst_meas_retries", retries, 0);
    chk("arst_meas_dcm_rst", dcm_rst, 1);

    // Tolerance boundaries: exact transition counts placed inside one window
    for (int i = 0; i < 4; i++) begin
      tick(1);
      rst = 1'b1; lock_in = 1'b0; tog_left = 0;
      tick(2);
      rst = 1'b0;
      tick(10);  lock_in = 1'b1;
      tick(10);  tog_period = 9; tog_ph = 0; tog_left = bnd_n[i];
      tick(993);
      chk($sformatf("bnd%0d_clk_ok", bnd_n[i]), clk_ok, bnd_pass[i]);
      chk($sformatf("bnd%0d_retries", bnd_n[i]), retries, bnd_pass[i] ? 0 : 1);
      chk($sformatf("bnd%0d_dcm_rst", bnd_n[i]), dcm_rst, bnd_pass[i] ? 0 : 1);
    end

    // Lock lost on the last window cycle with a valid count
    rst = 1'b1; lock_in = 1'b0;
    tog_period = 10; tog_ph = 0; tog_left = -1;
    tick(2);
    rst = 1'b0;
    tick(10);  lock_in = 1'b1;
    tick(1000); lock_in = 1'b0;
    tick(3);   chk("sim_clk_ok", clk_ok, 0);
    chk("sim_dcm_rst", dcm_rst, 1);
    chk("sim_retries", retries, 1);

    // Lock timeout with LOCK_TIMEOUT=200: re-pulse every 208 cycles, then FAULT
    rst = 1'b1; lock_in = 1'b0; tog_left = 0;
    tick(2);
    rst = 1'b0;
    tick(207); chk("to1_dcm_rst_low", dcm_rst, 0);
    tick(1);   chk("to1_dcm_rst", dcm_rst, 1);
    chk("to1_retries", retries, 1);
    tick(8);   chk("to2_dcm_rst_low", dcm_rst, 0);
    tick(407); chk("to3_fault_pre", fault, 0);
    chk("to3_retries_pre", retries, 2);
    tick(1);   chk("to3_fault", fault, 1);
    chk("to3_retries", retries, 3);
    chk("to3_dcm_rst", dcm_rst, 1);
    lock_in = 1'b1;
    tog_period = 10; tog_ph = 0; tog_left = -1;
    tick(1500); chk("fault_sticky", fault, 1);
    chk("fault_clk_ok", clk_ok, 0);
    chk("fault_dcm_rst", dcm_rst, 1);
    chk("fault_retries", retries, 3);

    // Asynchronous reset out of FAULT and clean restart
    #3 rst = 1'b1;
    #1 chk("arst_fault_fault", fault, 0);
    chk("arst_fault_retries", retries, 0);
    chk("arst_fault_dcm_rst", dcm_rst, 1);
    tick(2);
    rst = 1'b0;
    tick(7);   chk("rs_dcm_rst_held", dcm_rst, 1);
    tick(1);   chk("rs_dcm_rst_fall", dcm_rst, 0);
    tick(1001); chk("rs_clk_ok", clk_ok, 1);
    chk("rs_fault", fault, 0);
    chk("rs_retries", retries, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
